// File: rtl/muldiv_seq.sv
// Iterative unsigned 32-bit multiply (shift-add) / divide (restoring) sequencer.
// All adds/subtracts go through the borrowed shared ALU; shifts and compares stay local.
module muldiv_seq #(
    parameter int          XLEN   = 32,
    parameter int          ITERS  = 32,
    parameter logic [5:0]  FN_ADD = 6'b010000,
    parameter logic [5:0]  FN_SUB = 6'b010001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] rem,
    output logic            div_zero,
    output logic [5:0]      alu_fn,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_y
);

    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t          state_r, state_next_s;
    logic [CW-1:0]   count_r;
    logic            op_r;
    logic [XLEN-1:0] acc_r, mcand_r, mplier_r;
    logic [XLEN-1:0] part_rem_r, quo_r, dvsr_r;
    logic [XLEN-1:0] result_r, rem_out_r;
    logic            div_zero_r, busy_r, done_r;

    logic [XLEN:0]   rsh_s;
    logic            ge_s, last_s;
    logic [XLEN-1:0] acc_next_s, quo_next_s, prem_next_s;
    logic [5:0]      alu_fn_s;
    logic [XLEN-1:0] alu_a_s, alu_b_s;

    // Next-state decode, ALU operand steering and per-iteration datapath values
    always_comb begin
        state_next_s = state_r;
        alu_fn_s     = FN_ADD;
        alu_a_s      = {XLEN{1'b0}};
        alu_b_s      = {XLEN{1'b0}};
        rsh_s        = {part_rem_r, quo_r[XLEN-1]};
        ge_s         = (rsh_s >= {1'b0, dvsr_r});
        last_s       = (count_r == CW'(ITERS - 1));
        acc_next_s   = mplier_r[0] ? alu_y : acc_r;
        quo_next_s   = {quo_r[XLEN-2:0], ge_s};
        // A set rsh[32] implies rsh >= dvsr, so the 32-bit ALU difference is exact
        prem_next_s  = ge_s ? alu_y : rsh_s[XLEN-1:0];
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_next_s = S_RUN;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (op_r) begin
                    alu_fn_s = FN_SUB;
                    alu_a_s  = rsh_s[XLEN-1:0];
                    alu_b_s  = dvsr_r;
                end else begin
                    alu_fn_s = FN_ADD;
                    alu_a_s  = acc_r;
                    alu_b_s  = mcand_r;
                end
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == S_RUN);
            done_r  <= (state_next_s == S_DONE);
        end
    end

    // Operand latch, iteration datapath and result capture on the final iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r    <= {CW{1'b0}};
            op_r       <= 1'b0;
            acc_r      <= {XLEN{1'b0}};
            mcand_r    <= {XLEN{1'b0}};
            mplier_r   <= {XLEN{1'b0}};
            part_rem_r <= {XLEN{1'b0}};
            quo_r      <= {XLEN{1'b0}};
            dvsr_r     <= {XLEN{1'b0}};
            result_r   <= {XLEN{1'b0}};
            rem_out_r  <= {XLEN{1'b0}};
            div_zero_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        op_r       <= op;
                        count_r    <= {CW{1'b0}};
                        acc_r      <= {XLEN{1'b0}};
                        mcand_r    <= src_a;
                        mplier_r   <= src_b;
                        part_rem_r <= {XLEN{1'b0}};
                        quo_r      <= src_a;
                        dvsr_r     <= src_b;
                    end
                end
                S_RUN: begin
                    if (op_r) begin
                        part_rem_r <= prem_next_s;
                        quo_r      <= quo_next_s;
                    end else begin
                        acc_r    <= acc_next_s;
                        mcand_r  <= {mcand_r[XLEN-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
                    end
                    if (last_s) begin
                        if (op_r) begin
                            result_r   <= quo_next_s;
                            rem_out_r  <= prem_next_s;
                            div_zero_r <= (dvsr_r == {XLEN{1'b0}});
                        end else begin
                            result_r   <= acc_next_s;
                            rem_out_r  <= {XLEN{1'b0}};
                            div_zero_r <= 1'b0;
                        end
                    end else begin
                        count_r <= count_r + CW'(1);
                    end
                end
                S_DONE: begin
                    count_r <= count_r;
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign result   = result_r;
    assign rem      = rem_out_r;
    assign div_zero = div_zero_r;
    assign alu_fn   = alu_fn_s;
    assign alu_a    = alu_a_s;
    assign alu_b    = alu_b_s;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural shared-ALU model.
module tb_muldiv_seq;

    localparam logic [5:0] FN_ADD = 6'b010000;
    localparam logic [5:0] FN_SUB = 6'b010001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] result, rem, alu_a, alu_b, alu_y;
    logic [5:0]  alu_fn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared ALU stand-in; unknown fn codes yield a marker value
    assign alu_y = (alu_fn == FN_ADD) ? alu_a + alu_b :
                   (alu_fn == FN_SUB) ? alu_a - alu_b : 32'hBAD0BAD0;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .rem(rem), .div_zero(div_zero),
        .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for done (bounded), counting busy cycles and watching the ALU fn.
    // At lat==inj a competing start with other operands is pulsed for one cycle.
    task automatic wait_done(input logic [5:0] fn_exp, input int inj,
                             output int lat, output int busy_cnt, output bit fn_ok);
        lat = 0; busy_cnt = 0; fn_ok = 1'b1;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                if (alu_fn !== fn_exp) fn_ok = 1'b0;
            end
            if (lat == inj) begin
                start = 1'b1; op = 1'b0; src_a = 32'd55; src_b = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [31:0] erm, input logic edz,
                          input int inj, input bit poke_done);
        int lat, bc;
        bit fok;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = ~o; src_a = 32'h13572468; src_b = 32'h0000_0003;
        wait_done(o ? FN_SUB : FN_ADD, inj, lat, bc, fok);
        check({tag, "_latency"}, lat, 32'd32);
        check({tag, "_busy_cycles"}, bc, 32'd32);
        check({tag, "_run_fn"}, {31'd0, fok}, 32'd1);
        check({tag, "_result"}, result, er);
        check({tag, "_rem"}, rem, erm);
        check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, edz});
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_fn"}, {26'd0, alu_fn}, {26'd0, FN_ADD});
        check({tag, "_done_alu_a"}, alu_a, 32'd0);
        if (poke_done) begin
            start = 1'b1; op = 1'b0; src_a = 32'd3; src_b = 32'd3;
        end else begin
            start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_result_hold"}, result, er);
    endtask

    initial begin
        int bad_done, bad_busy;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rem", rem, 32'd0);
        check("reset_div_zero", {31'd0, div_zero}, 32'd0);
        check("reset_alu_fn", {26'd0, alu_fn}, {26'd0, FN_ADD});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6",      1'b0, 32'd7,        32'd6,       32'd42,       32'd0,    1'b0, -1, 1'b0);
        run_op("mul_wrap1",    1'b0, 32'hFFFFFFFF, 32'd2,       32'hFFFFFFFE, 32'd0,    1'b0, -1, 1'b0);
        run_op("mul_wrap2",    1'b0, 32'h10000,    32'h10000,   32'd0,        32'd0,    1'b0, -1, 1'b0);
        run_op("div_100_7",    1'b1, 32'd100,      32'd7,       32'd14,       32'd2,    1'b0, -1, 1'b0);
        run_op("div_max_1",    1'b1, 32'hFFFFFFFF, 32'd1,       32'hFFFFFFFF, 32'd0,    1'b0, -1, 1'b0);
        run_op("div_5_9",      1'b1, 32'd5,        32'd9,       32'd0,        32'd5,    1'b0, -1, 1'b0);
        run_op("div_by_zero",  1'b1, 32'd1234,     32'd0,       32'hFFFFFFFF, 32'd1234, 1'b1, -1, 1'b0);
        run_op("mul_clears_dz",1'b0, 32'd123456,   32'd1000,    32'd123456000,32'd0,    1'b0, -1, 1'b0);

        // Competing starts mid-run and in the DONE cycle must be ignored
        run_op("div_ignored",  1'b1, 32'd100,      32'd7,       32'd14,       32'd2,    1'b0,  5, 1'b1);
        bad_done = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            if (done !== 1'b0) bad_done++;
            if (busy !== 1'b0) bad_busy++;
            @(negedge clk);
        end
        check("hold_no_done", bad_done, 32'd0);
        check("hold_no_busy", bad_busy, 32'd0);
        check("hold_result", result, 32'd14);
        check("hold_rem", rem, 32'd2);

        // Asynchronous reset mid-run aborts the operation at once
        @(negedge clk);
        start = 1'b1; op = 1'b0; src_a = 32'd1000; src_b = 32'd1000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_result", result, 32'd0);
        check("areset_rem", rem, 32'd0);
        check("areset_alu_fn", {26'd0, alu_fn}, {26'd0, FN_ADD});
        check("areset_alu_a", alu_a, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad_done++;
            @(negedge clk);
        end
        check("abort_no_done", bad_done, 32'd0);
        run_op("mul_9x9",      1'b0, 32'd9,        32'd9,       32'd81,       32'd0,    1'b0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
